// File: rtl/acia_poll_master.sv
// acia_poll_master: polls an MC6850-style ACIA status register and moves
// bytes between its data register and valid/ready byte streams.
module acia_poll_master #(
  parameter int POLL_GAP     = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       resetn,
  output logic       acia_ce,
  output logic       acia_addr,
  output logic       acia_rd,
  output logic       acia_we,
  output logic [7:0] acia_dout,
  input  logic [7:0] acia_din,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready
);

  localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [GW-1:0] GAP_INIT = GW'(POLL_GAP);
  localparam logic [LW-1:0] LAT_INIT = LW'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    ST_RD,
    ST_WT,
    DR_RD,
    DR_WT,
    DW
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [GW-1:0] gap;
  logic [LW-1:0] lat;
  logic          lat_done;
  logic          rdrf;
  logic          tdre;
  logic          unused_status;

  assign lat_done      = (lat == '0);
  assign rdrf          = acia_din[0];
  assign tdre          = acia_din[1];
  assign unused_status = ^acia_din[7:2];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    acia_ce   = 1'b0;
    acia_addr = 1'b0;
    acia_rd   = 1'b0;
    acia_we   = 1'b0;
    acia_dout = 8'h00;
    tx_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        if (gap == '0) state_n = ST_RD;
      end
      ST_RD: begin
        acia_ce = 1'b1;
        acia_rd = 1'b1;
        state_n = ST_WT;
      end
      ST_WT: begin
        // RX wins over TX so the ACIA never overruns while we transmit
        if (lat_done) begin
          if (rdrf && !rx_valid) begin
            state_n = DR_RD;
          end else if (tdre && tx_valid) begin
            state_n = DW;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DR_RD: begin
        acia_ce   = 1'b1;
        acia_addr = 1'b1;
        acia_rd   = 1'b1;
        state_n   = DR_WT;
      end
      DR_WT: begin
        if (lat_done) state_n = IDLE;
      end
      DW: begin
        acia_ce   = 1'b1;
        acia_addr = 1'b1;
        acia_we   = 1'b1;
        acia_dout = tx_data;
        tx_ready  = 1'b1;
        state_n   = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      gap      <= GAP_INIT;
      lat      <= LAT_INIT;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      if (state_n == IDLE && state != IDLE) begin
        gap <= GAP_INIT;
      end else if (state == IDLE && gap != '0) begin
        gap <= gap - 1'b1;
      end
      if (state == ST_RD || state == DR_RD) begin
        lat <= LAT_INIT;
      end else if (!lat_done) begin
        lat <= lat - 1'b1;
      end
      if (state == DR_WT && lat_done) begin
        rx_data  <= acia_din;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_acia_poll_master.sv
// tb_acia_poll_master: behavioural ACIA model plus in-order RX/TX
// scoreboards; directed timing scenarios followed by random traffic.
module tb_acia_poll_master;

  localparam int GAP  = 16;
  localparam int LAT  = 1;
  localparam int POLL = GAP + LAT + 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       acia_ce;
  logic       acia_addr;
  logic       acia_rd;
  logic       acia_we;
  logic [7:0] acia_dout;
  logic [7:0] acia_din = 8'h00;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;

  acia_poll_master #(
    .POLL_GAP    (GAP),
    .READ_LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .acia_ce  (acia_ce),
    .acia_addr(acia_addr),
    .acia_rd  (acia_rd),
    .acia_we  (acia_we),
    .acia_dout(acia_dout),
    .acia_din (acia_din),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  byte unsigned exp_rx[$];
  byte unsigned exp_tx[$];
  byte unsigned line_rx[$];
  logic        tdre = 1'b0;
  logic        noise = 1'b0;
  logic [7:0]  last_stat = 8'h00;
  logic [7:0]  stat_now;
  int          drd_cnt = 0;
  int          we_cnt = 0;
  int unsigned last_drd = 0;
  int unsigned last_we = 0;
  logic        prev_rd = 1'b0;
  logic        prev_we = 1'b0;
  logic        tx_done = 1'b0;
  logic        rxg_done = 1'b0;
  int          n;
  int          k;
  int          w;
  int unsigned prev;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tx(input byte unsigned b);
    int t;
    t = 0;
    exp_tx.push_back(b);
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && t < 3000) begin
      tick();
      t++;
    end
    check("tx_timeout", 32'(t < 3000), 1);
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'h00;
  endtask

  // ACIA: registered read data, status derived from its receive queue
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (acia_rd && !acia_addr) begin
      stat_now  = {noise ? 6'($urandom) : 6'd0, tdre, line_rx.size() != 0};
      last_stat = stat_now;
      acia_din <= stat_now;
    end
    if (acia_rd && acia_addr) begin
      check("rd_rdrf", 32'(last_stat[0]), 1);
      check("rd_avail", 32'(line_rx.size() != 0), 1);
      if (line_rx.size() != 0) acia_din <= line_rx.pop_front();
      else acia_din <= 8'h00;
    end
    if (acia_we) begin
      check("we_tdre", 32'(last_stat[1]), 1);
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("bus", {26'd0,
                    acia_ce ^ (acia_rd | acia_we),
                    acia_rd & acia_we,
                    tx_ready ^ acia_we,
                    !(acia_rd | acia_we) && (acia_addr || acia_dout != 0),
                    prev_rd & acia_rd,
                    prev_we & acia_we}, 0);
      prev_rd = acia_rd;
      prev_we = acia_we;
      if (acia_rd && acia_addr) begin
        drd_cnt++;
        last_drd = cyc;
      end
      if (acia_we) begin
        we_cnt++;
        last_we = cyc;
        check("we_addr", 32'(acia_addr), 1);
        check("tx_pending", 32'(exp_tx.size() != 0), 1);
        if (exp_tx.size() != 0) check("tx_byte", 32'(acia_dout), 32'(exp_tx.pop_front()));
      end
      if (rx_valid && rx_ready) begin
        check("rx_pending", 32'(exp_rx.size() != 0), 1);
        if (exp_rx.size() != 0) check("rx_byte", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
    end
  end

  initial begin
    // reset held with a pending TX byte
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    repeat (3) begin
      tick();
      check("rst_quiet", {28'd0, acia_rd, acia_we, rx_valid, tx_ready}, 0);
    end
    resetn   = 1'b1;
    tx_valid = 1'b0;
    n = 0;
    while (!acia_rd && n < 100) begin tick(); n++; end
    check("first_poll", n, GAP + 1);

    // RX and stall while holding register is full
    line_rx.push_back(8'hA5);
    exp_rx.push_back(8'hA5);
    n = 0;
    while (!rx_valid && n < 200) begin tick(); n++; end
    check("rx_arrive", 32'(rx_valid), 1);
    check("rx_data", 32'(rx_data), 32'hA5);
    k = drd_cnt;
    line_rx.push_back(8'h3C);
    exp_rx.push_back(8'h3C);
    repeat (3 * POLL + 2) tick();
    check("rx_stall", drd_cnt, k);
    check("rx_hold", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'hA5});
    rx_ready = 1'b1;
    n = 0;
    while ((exp_rx.size() != 0 || rx_valid) && n < 200) begin tick(); n++; end
    check("rx_drain", exp_rx.size(), 0);

    // single TX byte
    tdre = 1'b1;
    w = we_cnt;
    send_tx(8'h8D);
    repeat (3 * POLL) tick();
    check("tx_once", we_cnt, w + 1);

    // RX before TX when both are pending
    line_rx.push_back(8'h42);
    exp_rx.push_back(8'h42);
    send_tx(8'h41);
    n = 0;
    while ((exp_rx.size() != 0 || rx_valid) && n < 200) begin tick(); n++; end
    check("prio_rx", exp_rx.size(), 0);
    check("prio_order", last_we - last_drd, GAP + 2 * LAT + 3);

    // empty status, TX offered but never accepted
    tdre     = 1'b0;
    tx_data  = 8'hEE;
    tx_valid = 1'b1;
    k = drd_cnt;
    w = we_cnt;
    n = 0;
    while (!(acia_rd && !acia_addr) && n < 100) begin tick(); n++; end
    check("poll_seen", 32'(acia_rd & !acia_addr), 1);
    prev = cyc;
    for (int i = 0; i < 9; i++) begin
      tick();
      n = 0;
      while (!(acia_rd && !acia_addr) && n < 100) begin tick(); n++; end
      check("poll_gap", cyc - prev, POLL);
      prev = cyc;
    end
    check("poll_no_drd", drd_cnt, k);
    check("poll_no_we", we_cnt, w);
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    // reset during the data-read wait aborts the capture
    rx_ready = 1'b0;
    line_rx.push_back(8'h77);
    n = 0;
    while (!(acia_rd && acia_addr) && n < 100) begin tick(); n++; end
    check("dr_seen", 32'(acia_rd & acia_addr), 1);
    tick();
    resetn = 1'b0;
    tick();
    check("abort", {29'd0, rx_valid, acia_rd, acia_we}, 0);
    resetn = 1'b1;
    n = 0;
    while (!acia_rd && n < 100) begin tick(); n++; end
    check("resume", n, GAP + 1);
    check("no_capture", 32'(rx_valid), 0);

    // random traffic with noisy status bits
    noise = 1'b1;
    fork
      begin : tx_gen
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 40)) tick();
          send_tx(8'($urandom));
        end
        tx_done = 1'b1;
      end
      begin : rx_gen
        byte unsigned b;
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 60)) tick();
          b = 8'($urandom);
          line_rx.push_back(b);
          exp_rx.push_back(b);
        end
        rxg_done = 1'b1;
      end
      begin : jitter
        int c;
        c = 0;
        while (!(tx_done && rxg_done) && c < 20000) begin
          tick();
          tdre     = 1'($urandom_range(0, 1));
          rx_ready = 1'($urandom_range(0, 1));
          c++;
        end
      end
    join
    tdre     = 1'b1;
    rx_ready = 1'b1;
    n = 0;
    while ((exp_rx.size() != 0 || exp_tx.size() != 0 || rx_valid) && n < 2000) begin
      tick();
      n++;
    end
    check("drain", {29'd0, exp_rx.size() != 0, exp_tx.size() != 0, rx_valid}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
